// File: rtl/eb1_lsu_clken_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : eb1_lsu_clken_ctrl
// Purpose  : NUM_CH-channel LSU clock-enable controller with hold-off
//            hysteresis, optional channel chaining and per-channel gated clocks.
//            Optional activity counters enabled by macro EB1_CLKEN_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module eb1_lsu_clken_ctrl #(
  parameter int                NUM_CH = 8,
  parameter int                HOLD_W = 4,
  parameter logic [NUM_CH-1:0] CHAIN  = '0,
  parameter int                CNT_W  = 16,
  localparam int               SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       scan_mode,
  input  logic                       clk_override,
  input  logic                       force_on,
  input  logic [NUM_CH-1:0]          req,
  input  logic [NUM_CH*HOLD_W-1:0]   hold_cycles,
  output logic [NUM_CH-1:0]          c1_clken,
  output logic [NUM_CH-1:0]          c2_clken,
  output logic [NUM_CH-1:0]          c1_clk,
  output logic [NUM_CH-1:0]          c2_clk,
  output logic                       all_idle,
  input  logic [SEL_W-1:0]           stat_sel,
  input  logic                       stat_clr,
  output logic [CNT_W-1:0]           stat_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  logic [NUM_CH-1:0] r_c1_q;
  logic [NUM_CH-1:0] w_eff_req;
  logic [NUM_CH-1:0] w_c1;
  logic [NUM_CH-1:0] w_c2;
  logic [NUM_CH-1:0] w_next_idle;
  logic              w_force;
  logic              r_all_idle;

  assign w_force = clk_override | force_on;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_cnt_nxt;
    logic [HOLD_W-1:0] w_hold;
    logic              r_c1_en_lat;
    logic              r_c2_en_lat;

    assign w_hold = hold_cycles[i*HOLD_W +: HOLD_W];

    if (i == 0) begin : g_head
      assign w_eff_req[i] = req[i];
    end else begin : g_link
      assign w_eff_req[i] = req[i] | (CHAIN[i] & r_c1_q[i-1]);
    end

    // The first cycle after the request drops (ACTIVE) is hold cycle 1;
    // r_hold_cnt then counts the hold cycles still owed in HOLD.
    always_comb begin
      w_state_nxt    = r_state;
      w_hold_cnt_nxt = r_hold_cnt;
      case (r_state)
        S_IDLE: begin
          if (w_eff_req[i]) w_state_nxt = S_ACTIVE;
        end
        S_ACTIVE: begin
          if (!w_eff_req[i]) begin
            if (w_hold <= HOLD_W'(1)) begin
              w_state_nxt    = S_IDLE;
              w_hold_cnt_nxt = '0;
            end else begin
              w_state_nxt    = S_HOLD;
              w_hold_cnt_nxt = w_hold - HOLD_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (w_eff_req[i]) begin
            w_state_nxt    = S_ACTIVE;
            w_hold_cnt_nxt = '0;
          end else if (r_hold_cnt <= HOLD_W'(1)) begin
            w_state_nxt    = S_IDLE;
            w_hold_cnt_nxt = '0;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt - HOLD_W'(1);
          end
        end
        default: begin
          w_state_nxt    = S_IDLE;
          w_hold_cnt_nxt = '0;
        end
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state    <= S_IDLE;
        r_hold_cnt <= '0;
      end else begin
        r_state    <= w_state_nxt;
        r_hold_cnt <= w_hold_cnt_nxt;
      end
    end

    assign w_c1[i] = ~rst & (w_eff_req[i]
                             | ((r_state == S_ACTIVE) & (|w_hold))
                             | (r_state == S_HOLD)
                             | w_force);
    assign w_c2[i] = ~rst & (w_c1[i] | r_c1_q[i] | w_force);

    assign w_next_idle[i] = (w_state_nxt == S_IDLE) & ~w_eff_req[i] & ~w_c1[i];

    // Clock headers: enable captured while clk is low, so it gates the next high phase.
    always_latch begin
      if (!clk) begin
        r_c1_en_lat <= w_c1[i] | scan_mode;
        r_c2_en_lat <= w_c2[i] | scan_mode;
      end
    end

    assign c1_clk[i] = clk & r_c1_en_lat;
    assign c2_clk[i] = clk & r_c2_en_lat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c1_q     <= '0;
      r_all_idle <= 1'b1;
    end else begin
      r_c1_q     <= w_c1;
      r_all_idle <= &w_next_idle;
    end
  end

  assign c1_clken = w_c1;
  assign c2_clken = w_c2;
  assign all_idle = r_all_idle;

`ifdef EB1_CLKEN_STATS_EN
  logic [CNT_W-1:0] r_cnt [NUM_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (stat_clr)                     r_cnt[k] <= '0;
        else if (w_c1[k] && !(&r_cnt[k])) r_cnt[k] <= r_cnt[k] + CNT_W'(1);
      end
    end
  end

  assign stat_cnt = (int'(stat_sel) < NUM_CH) ? r_cnt[stat_sel] : '0;
`else
  logic w_unused_stats;
  assign w_unused_stats = ^{stat_sel, stat_clr};
  assign stat_cnt       = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eb1_lsu_clken_ctrl.sv
`default_nettype none
// Randomized scoreboard bench for eb1_lsu_clken_ctrl against a hold-remaining
// reference model (works with or without EB1_CLKEN_STATS_EN).
module tb_eb1_lsu_clken_ctrl;

  localparam int          NUM_CH = 5;
  localparam int          HOLD_W = 3;
  localparam int          CNT_W  = 6;
  localparam logic [4:0]  CHAIN  = 5'b10110;
  localparam int          NCYC   = 3000;

  logic                      clk = 1'b0;
  logic                      rst, scan_mode, clk_override, force_on, stat_clr;
  logic [NUM_CH-1:0]         req;
  logic [NUM_CH*HOLD_W-1:0]  hold_cycles;
  logic [2:0]                stat_sel;
  logic [NUM_CH-1:0]         c1_clken, c2_clken, c1_clk, c2_clk;
  logic                      all_idle;
  logic [CNT_W-1:0]          stat_cnt;

  eb1_lsu_clken_ctrl #(
    .NUM_CH(NUM_CH), .HOLD_W(HOLD_W), .CHAIN(CHAIN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .scan_mode(scan_mode), .clk_override(clk_override),
    .force_on(force_on), .req(req), .hold_cycles(hold_cycles),
    .c1_clken(c1_clken), .c2_clken(c2_clken), .c1_clk(c1_clk), .c2_clk(c2_clk),
    .all_idle(all_idle), .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_cnt(stat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH-1:0] c1;
    logic [NUM_CH-1:0] c2;
    logic              idle;
    logic [CNT_W-1:0]  stat;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: rem[i] = hold cycles still owed after the request drops.
  int          rem [NUM_CH];
  int          cnt [NUM_CH];
  bit          c1q [NUM_CH];
  bit          eff [NUM_CH];
  bit          c1m [NUM_CH];
  bit          c2m [NUM_CH];
  bit          idle_m;
  logic [4:0]  chain_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      rem[i] = 0; cnt[i] = 0; c1q[i] = 0;
    end
    idle_m = 1;
  endfunction

  function automatic void model_comb();
    bit frc;
    frc = clk_override || force_on;
    for (int i = 0; i < NUM_CH; i++) begin
      eff[i] = req[i];
      if (i > 0 && chain_v[i] && c1q[i-1]) eff[i] = 1;
      c1m[i] = !rst && (eff[i] || rem[i] > 0 || frc);
      c2m[i] = !rst && (c1m[i] || c1q[i] || frc);
    end
  endfunction

  function automatic void model_step();
    bit idle_n;
    int h, remn;
    if (rst) begin
      model_reset();
      return;
    end
    idle_n = 1;
    for (int i = 0; i < NUM_CH; i++) begin
      h    = int'(hold_cycles[i*HOLD_W +: HOLD_W]);
      remn = eff[i] ? h : (rem[i] > 0 ? rem[i] - 1 : 0);
      if (eff[i] || remn != 0 || c1m[i]) idle_n = 0;
`ifdef EB1_CLKEN_STATS_EN
      if (stat_clr)                            cnt[i] = 0;
      else if (c1m[i] && cnt[i] < (1 << CNT_W) - 1) cnt[i] = cnt[i] + 1;
`endif
      rem[i] = remn;
      c1q[i] = c1m[i];
    end
    idle_m = idle_n;
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    for (int i = 0; i < NUM_CH; i++) begin
      e.c1[i] = c1m[i];
      e.c2[i] = c2m[i];
    end
    e.idle = idle_m;
    e.stat = (int'(stat_sel) < NUM_CH) ? CNT_W'(cnt[stat_sel]) : '0;
    return e;
  endfunction

  // Monitor: one expected entry per cycle, compared mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("c1_clken", 32'(c1_clken), 32'(e.c1));
      check("c2_clken", 32'(c2_clken), 32'(e.c2));
      check("all_idle", 32'(all_idle), 32'(e.idle));
      check("stat_cnt", 32'(stat_cnt), 32'(e.stat));
    end
  end

  initial begin
    logic [NUM_CH-1:0] prev_c1, prev_c2;
    logic              prev_scan;
    int                rst_left, pct;

    chain_v      = CHAIN;
    rst          = 1'b1;
    scan_mode    = 1'b0;
    clk_override = 1'b0;
    force_on     = 1'b0;
    stat_clr     = 1'b0;
    stat_sel     = '0;
    req          = '0;
    hold_cycles  = {3'd7, 3'd0, 3'd2, 3'd0, 3'd4};
    prev_c1      = '0;
    prev_c2      = '0;
    prev_scan    = 1'b0;
    rst_left     = 2;
    model_reset();

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      check("c1_clk", 32'(c1_clk), 32'(prev_c1 | {NUM_CH{prev_scan}}));
      check("c2_clk", 32'(c2_clk), 32'(prev_c2 | {NUM_CH{prev_scan}}));
      model_step();

      if (rst_left == 0 && $urandom_range(0, 299) == 0) begin
        rst_left = 2;
        for (int i = 0; i < NUM_CH; i++)
          hold_cycles[i*HOLD_W +: HOLD_W] = HOLD_W'($urandom_range(0, 7));
      end
      rst = (rst_left > 0);
      if (rst_left > 0) rst_left--;

      case ((cyc / 80) % 4)
        0:       pct = 10;
        1:       pct = 50;
        2:       pct = 95;
        default: pct = 3;
      endcase
      for (int i = 0; i < NUM_CH; i++) req[i] = ($urandom_range(0, 99) < pct);
      clk_override = ($urandom_range(0, 59) == 0);
      force_on     = ($urandom_range(0, 59) == 0);
      scan_mode    = ($urandom_range(0, 49) == 0);
      stat_clr     = ($urandom_range(0, 149) == 0);
      stat_sel     = 3'($urandom_range(0, 7));

      if (rst) model_reset();
      model_comb();
      q.push_back(model_exp());
      for (int i = 0; i < NUM_CH; i++) begin
        prev_c1[i] = c1m[i];
        prev_c2[i] = c2m[i];
      end
      prev_scan = scan_mode;
    end

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d entries left expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
